// File: rtl/dp_ram_fifo_ctrl_pkg.sv
// Shared types for the dual-port-RAM FIFO controller: the read-side state
// encoding and helpers that translate between the state and the
// (read pending, words held in skid) pair it stands for.
package dp_ram_fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    RD_IDLE        = 3'd0,
    RD_FETCH       = 3'd1,
    RD_HOLD1       = 3'd2,
    RD_HOLD1_FETCH = 3'd3,
    RD_HOLD2       = 3'd4
  } rd_state_e;

  function automatic rd_state_e rd_state_encode(input logic pend, input logic [1:0] held);
    rd_state_e s;
    case ({pend, held})
      3'b000:  s = RD_IDLE;
      3'b100:  s = RD_FETCH;
      3'b001:  s = RD_HOLD1;
      3'b101:  s = RD_HOLD1_FETCH;
      default: s = RD_HOLD2;
    endcase
    return s;
  endfunction

  function automatic logic rd_state_pending(input rd_state_e s);
    return (s == RD_FETCH) || (s == RD_HOLD1_FETCH);
  endfunction

endpackage

// File: rtl/dp_ram_fifo_ctrl_skid_buf2.sv
// Two-entry register FIFO that absorbs the RAM's one-cycle read latency.
// Head is the oldest word and drives the output directly.
module dp_ram_fifo_ctrl_skid_buf2 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [1:0]            cnt_q;

  // Storage and occupancy; flush drops the count but leaves stale data,
  // which is never visible because valid_o follows the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= push_data_i;
          else               tail_q <= push_data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= push_data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = head_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// Streaming FIFO controller around an external simple dual-port RAM
// (port A write, port B registered read). Owns both pointers, hides the
// read latency behind a 2-entry skid buffer and reports total occupancy.
//
// Read-side states (read pending x words in skid):
//   state          | meaning
//   RD_IDLE        | nothing in flight, skid empty
//   RD_FETCH       | one RAM read in flight, skid empty
//   RD_HOLD1       | skid holds one word, no read in flight
//   RD_HOLD1_FETCH | skid holds one word, one read in flight
//   RD_HOLD2       | skid full, no further reads until a pop
module dp_ram_fifo_ctrl #(
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = $clog2(RAM_DEPTH + 3)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  ram_ena_o,
  output logic                  ram_wea_o,
  output logic [ADDR_WIDTH-1:0] ram_addra_o,
  output logic [DATA_WIDTH-1:0] ram_dia_o,
  output logic                  ram_enb_o,
  output logic [ADDR_WIDTH-1:0] ram_addrb_o,
  input  logic [DATA_WIDTH-1:0] ram_dob_i
);

  import dp_ram_fifo_ctrl_pkg::*;

  localparam int RC_W = $clog2(RAM_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [RC_W-1:0]       ram_cnt_q, ram_cnt_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  in_ready_q, in_ready_d;
  rd_state_e             state_q, state_d;

  logic       push, pop, issue, cap, rd_pend, skid_valid;
  logic [1:0] skid_cnt, skid_cnt_d;
  logic [2:0] rd_occ;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_pend = rd_state_pending(state_q);

  // Handshakes and read issue. A pop in the same cycle frees a skid slot,
  // which keeps one word per cycle flowing with the consumer always ready.
  always_comb begin
    push   = in_valid_i & in_ready_q & ~flush_i;
    pop    = skid_valid & out_ready_i & ~flush_i;
    cap    = rd_pend & ~flush_i;
    rd_occ = {1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, pop};
    issue  = (ram_cnt_q != '0) & (rd_occ < 3'd2) & ~flush_i;
  end

  // Next-state for pointers, occupancy counters and the ready flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    count_d    = count_q;
    skid_cnt_d = skid_cnt;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      count_d    = '0;
      skid_cnt_d = 2'd0;
    end else begin
      if (push)  wr_ptr_d = ptr_inc(wr_ptr_q);
      if (issue) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, issue})
        2'b10:   ram_cnt_d = ram_cnt_q + RC_W'(1);
        2'b01:   ram_cnt_d = ram_cnt_q - RC_W'(1);
        default: ram_cnt_d = ram_cnt_q;
      endcase
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
      if (cap) skid_cnt_d = skid_cnt_d + 2'd1;
      if (pop) skid_cnt_d = skid_cnt_d - 2'd1;
    end
    in_ready_d = (ram_cnt_d < RC_W'(RAM_DEPTH)) & ~flush_i;
    state_d    = rd_state_encode(issue, skid_cnt_d);
  end

  // Write/read pointers, RAM occupancy, total count and registered ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Read-side state machine; its state carries the read-pending flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RD_IDLE;
    else       state_q <= state_d;
  end

  dp_ram_fifo_ctrl_skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_i     (cap),
    .push_data_i(ram_dob_i),
    .pop_i      (pop),
    .valid_o    (skid_valid),
    .head_o     (out_data_o),
    .cnt_o      (skid_cnt)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = skid_valid;
  assign count_o     = count_q;
  assign ram_ena_o   = push;
  assign ram_wea_o   = push;
  assign ram_addra_o = wr_ptr_q;
  assign ram_dia_o   = in_data_i;
  assign ram_enb_o   = issue;
  assign ram_addrb_o = rd_ptr_q;

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
module tb_dp_ram_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: RAM_DEPTH = 16
  logic        a_flush, a_in_valid, a_out_ready;
  logic [63:0] a_in_data;
  logic        a_in_ready, a_out_valid;
  logic [63:0] a_out_data;
  logic [4:0]  a_count;
  logic        a_ena, a_wea, a_enb;
  logic [3:0]  a_addra, a_addrb;
  logic [63:0] a_dia, a_dob;
  logic [63:0] a_mem [16];

  // Instance B: RAM_DEPTH = 5
  logic        b_flush, b_in_valid, b_out_ready;
  logic [63:0] b_in_data;
  logic        b_in_ready, b_out_valid;
  logic [63:0] b_out_data;
  logic [2:0]  b_count;
  logic        b_ena, b_wea, b_enb;
  logic [2:0]  b_addra, b_addrb;
  logic [63:0] b_dia, b_dob;
  logic [63:0] b_mem [5];

  dp_ram_fifo_ctrl #(.RAM_DEPTH(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .count_o(a_count), .ram_ena_o(a_ena), .ram_wea_o(a_wea), .ram_addra_o(a_addra),
    .ram_dia_o(a_dia), .ram_enb_o(a_enb), .ram_addrb_o(a_addrb), .ram_dob_i(a_dob));

  dp_ram_fifo_ctrl #(.RAM_DEPTH(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .count_o(b_count), .ram_ena_o(b_ena), .ram_wea_o(b_wea), .ram_addra_o(b_addra),
    .ram_dia_o(b_dia), .ram_enb_o(b_enb), .ram_addrb_o(b_addrb), .ram_dob_i(b_dob));

  // Behavioural RAMs: synchronous write, registered read, no output reset.
  always @(posedge clk) begin
    if (a_ena && a_wea) a_mem[a_addra] <= a_dia;
    if (a_enb)          a_dob <= a_mem[a_addrb];
    if (b_ena && b_wea) b_mem[b_addra] <= b_dia;
    if (b_enb)          b_dob <= b_mem[b_addrb];
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        ordy;
    logic        e_rdy;
    logic        e_wea;
    logic        e_enb;
    logic        e_ov;
    logic        chk_d;
    logic [63:0] e_od;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic [63:0] d, logic ordy, logic e_rdy, logic e_wea,
                              logic e_enb, logic e_ov, logic chk_d, logic [63:0] e_od, int e_cnt);
    vec_t r;
    r.v = v; r.d = d; r.ordy = ordy; r.e_rdy = e_rdy; r.e_wea = e_wea; r.e_enb = e_enb;
    r.e_ov = e_ov; r.chk_d = chk_d; r.e_od = e_od; r.e_cnt = e_cnt;
    return r;
  endfunction

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, guard, cyc, peak, expv;
    logic [63:0] sb [$];
    logic [63:0] nextv;

    //          v  data     ordy rdy wea enb ov  chkd od       cnt
    vecs[0]  = mk(1, 64'hA1, 0,  1,  1,  0,  0,  0,  64'h0,   0);
    vecs[1]  = mk(0, 64'h0,  0,  1,  0,  1,  0,  0,  64'h0,   1);
    vecs[2]  = mk(0, 64'h0,  0,  1,  0,  0,  0,  0,  64'h0,   1);
    vecs[3]  = mk(0, 64'h0,  1,  1,  0,  0,  1,  1,  64'hA1,  1);
    vecs[4]  = mk(1, 64'hB2, 0,  1,  1,  0,  0,  0,  64'h0,   0);
    vecs[5]  = mk(1, 64'hC3, 0,  1,  1,  1,  0,  0,  64'h0,   1);
    vecs[6]  = mk(0, 64'h0,  0,  1,  0,  1,  0,  0,  64'h0,   2);
    vecs[7]  = mk(0, 64'h0,  0,  1,  0,  0,  1,  1,  64'hB2,  2);
    vecs[8]  = mk(0, 64'h0,  1,  1,  0,  0,  1,  1,  64'hB2,  2);
    vecs[9]  = mk(0, 64'h0,  1,  1,  0,  0,  1,  1,  64'hC3,  1);
    vecs[10] = mk(0, 64'h0,  0,  1,  0,  0,  0,  0,  64'h0,   0);

    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst.in_ready", 64'(a_in_ready), 64'd0);
    chk("rst.out_valid", 64'(a_out_valid), 64'd0);
    chk("rst.count", 64'(a_count), 64'd0);
    chk("rst.ram_ena", 64'(a_ena), 64'd0);
    chk("rst.ram_enb", 64'(a_enb), 64'd0);
    chk("rst.addra", 64'(a_addra), 64'd0);
    chk("rst.addrb", 64'(a_addrb), 64'd0);
    chk("rst.out_data", a_out_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.in_ready_still_low", 64'(a_in_ready), 64'd0);
    @(negedge clk);

    // Table-driven: first-word latency and a two-word burst
    for (int i = 0; i < 11; i++) begin
      a_in_valid  = vecs[i].v;
      a_in_data   = vecs[i].d;
      a_out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d.in_ready", i), 64'(a_in_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.ram_wea", i), 64'(a_wea), 64'(vecs[i].e_wea));
      chk($sformatf("vec%0d.ram_ena", i), 64'(a_ena), 64'(vecs[i].e_wea));
      chk($sformatf("vec%0d.ram_enb", i), 64'(a_enb), 64'(vecs[i].e_enb));
      chk($sformatf("vec%0d.out_valid", i), 64'(a_out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("vec%0d.count", i), 64'(a_count), 64'(vecs[i].e_cnt));
      if (vecs[i].chk_d) chk($sformatf("vec%0d.out_data", i), a_out_data, vecs[i].e_od);
      @(negedge clk);
    end
    a_in_valid = 0; a_out_ready = 0;

    // Fill to capacity (RAM_DEPTH + 2) with consumer stalled
    sent = 0; guard = 0;
    while (sent < 18 && guard < 100) begin
      a_in_valid = 1; a_in_data = 64'(sent + 1);
      #1;
      if (a_in_ready) sent++;
      @(negedge clk);
      guard++;
    end
    chk("full.accepted", 64'(sent), 64'd18);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("full.in_ready_low%0d", k), 64'(a_in_ready), 64'd0);
      chk($sformatf("full.count%0d", k), 64'(a_count), 64'd18);
      chk($sformatf("full.no_write%0d", k), 64'(a_ena), 64'd0);
      @(negedge clk);
    end
    a_in_valid = 0; a_out_ready = 1;
    expv = 1; guard = 0;
    while (expv <= 18 && guard < 80) begin
      #1;
      if (a_out_valid) begin
        chk($sformatf("drain.word%0d", expv), a_out_data, 64'(expv));
        expv++;
      end
      @(negedge clk);
      guard++;
    end
    chk("drain.all_words", 64'(expv), 64'd19);
    #1;
    chk("drain.count_empty", 64'(a_count), 64'd0);
    chk("drain.out_valid_low", 64'(a_out_valid), 64'd0);
    @(negedge clk);

    // Continuous streaming, 100 words, consumer always ready
    sent = 0; rcv = 0; a_out_ready = 1;
    for (cyc = 0; cyc < 200 && rcv < 100; cyc++) begin
      a_in_valid = (sent < 100);
      a_in_data  = 64'(1000 + sent);
      #1;
      if (a_out_valid) begin
        chk($sformatf("thru.data%0d", rcv), a_out_data, 64'(1000 + rcv));
        chk($sformatf("thru.cycle%0d", rcv), 64'(cyc), 64'(3 + rcv));
        rcv++;
      end
      if (a_in_valid && a_in_ready) sent++;
      @(negedge clk);
    end
    chk("thru.received", 64'(rcv), 64'd100);
    a_in_valid = 0; a_out_ready = 0;
    @(negedge clk);

    // Depth-5 instance, random handshakes, scoreboard
    nextv = 64'h5000; sent = 0; rcv = 0; peak = 0;
    for (cyc = 0; cyc < 450; cyc++) begin
      b_in_valid  = (cyc < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      b_out_ready = (cyc < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
      b_in_data   = nextv;
      #1;
      chk($sformatf("rnd.count%0d", cyc), 64'(b_count), 64'(sb.size()));
      if (b_out_valid && b_out_ready) begin
        if (sb.size() == 0) chk("rnd.pop_from_empty", 64'(b_out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk($sformatf("rnd.data%0d", rcv), b_out_data, sb.pop_front());
        rcv++;
      end
      if (b_in_valid && b_in_ready) begin
        sb.push_back(nextv);
        nextv++;
        sent++;
      end
      if (sb.size() > peak) peak = sb.size();
      @(negedge clk);
    end
    chk("rnd.sb_empty", 64'(sb.size()), 64'd0);
    chk("rnd.all_received", 64'(rcv), 64'(sent));
    chk("rnd.peak_within_capacity", 64'(peak <= 7), 64'd1);
    b_in_valid = 0; b_out_ready = 0;

    // Flush with 7 words held and a read in flight
    a_out_ready = 0;
    for (int k = 0; k < 8; k++) begin
      a_in_valid = 1; a_in_data = 64'(16'h200 + k);
      #1;
      chk($sformatf("fl.fill_ready%0d", k), 64'(a_in_ready), 64'd1);
      @(negedge clk);
    end
    a_in_valid = 0;
    repeat (4) @(negedge clk);
    #1;
    chk("fl.count8", 64'(a_count), 64'd8);
    a_out_ready = 1;
    #1;
    chk("fl.pop_head", a_out_data, 64'h200);
    chk("fl.issue_on_pop", 64'(a_enb), 64'd1);
    @(negedge clk);
    a_out_ready = 0; a_flush = 1; a_in_valid = 1; a_in_data = 64'hDEAD;
    #1;
    chk("fl.count7_before", 64'(a_count), 64'd7);
    @(negedge clk);
    a_flush = 0; a_in_valid = 0;
    #1;
    chk("fl.count_zero", 64'(a_count), 64'd0);
    chk("fl.out_valid_low", 64'(a_out_valid), 64'd0);
    chk("fl.in_ready_low", 64'(a_in_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("fl.in_ready_back", 64'(a_in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("fl.no_stale%0d", k), 64'(a_out_valid), 64'd0);
      @(negedge clk);
    end
    a_in_valid = 1; a_in_data = 64'h77; a_out_ready = 1;
    #1;
    chk("fl.post_push_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    a_in_valid = 0;
    guard = 0;
    #1;
    while (!a_out_valid && guard < 10) begin
      @(negedge clk); #1; guard++;
    end
    chk("fl.first_out_seen", 64'(a_out_valid), 64'd1);
    chk("fl.first_out_data", a_out_data, 64'h77);
    @(negedge clk);
    #1;
    chk("fl.empty_after", 64'(a_count), 64'd0);
    @(negedge clk);

    // Asynchronous reset mid-stream
    a_out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      a_in_valid = 1; a_in_data = 64'(16'h300 + k);
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst.in_ready", 64'(a_in_ready), 64'd0);
    chk("arst.out_valid", 64'(a_out_valid), 64'd0);
    chk("arst.count", 64'(a_count), 64'd0);
    chk("arst.ram_ena", 64'(a_ena), 64'd0);
    chk("arst.ram_enb", 64'(a_enb), 64'd0);
    chk("arst.addra", 64'(a_addra), 64'd0);
    chk("arst.addrb", 64'(a_addrb), 64'd0);
    chk("arst.out_data", a_out_data, 64'd0);
    @(negedge clk);
    rst = 1'b0; a_in_valid = 0;
    @(negedge clk);
    a_in_valid = 1; a_in_data = 64'h55; a_out_ready = 1;
    #1;
    chk("arst.post_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    a_in_valid = 0;
    guard = 0;
    #1;
    while (!a_out_valid && guard < 10) begin
      @(negedge clk); #1; guard++;
    end
    chk("arst.first_out_seen", 64'(a_out_valid), 64'd1);
    chk("arst.first_out_data", a_out_data, 64'h55);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
